// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write-port bundle for mem_loader.
// The master modport is the loader side; the slave modport is the byte source plus memory.
interface mem_loader_if #(
  parameter int ADDRESS_WIDTH = 8
);
  // Handshake: a byte transfers on a rising edge where byte_valid_in and
  // byte_ready_out are both high. The source holds byte_data_in stable while
  // byte_valid_in is high and ready is low. Ready never depends on valid.
  logic [7:0]               byte_data_in;
  logic                     byte_valid_in;
  logic                     byte_ready_out;
  logic [31:0]              write_data_out;
  logic [ADDRESS_WIDTH-1:0] write_address_out;
  logic                     write_out;
  logic [1:0]               memMode_out;

  modport master (
    input  byte_data_in,
    input  byte_valid_in,
    output byte_ready_out,
    output write_data_out,
    output write_address_out,
    output write_out,
    output memMode_out
  );

  modport slave (
    output byte_data_in,
    output byte_valid_in,
    input  byte_ready_out,
    input  write_data_out,
    input  write_address_out,
    input  write_out,
    input  memMode_out
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: assembles big-endian words from a byte stream and writes them to consecutive
// word addresses. Optional running checksum enabled by defining MEM_LOADER_CHECKSUM_EN.
module mem_loader #(
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic                     start_in,
  input  logic [ADDRESS_WIDTH-1:0] base_address_in,
  input  logic [ADDRESS_WIDTH-2:0] word_count_in,
  mem_loader_if.master             bus,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [31:0]              checksum_out,
  output logic [1:0]               dbg_state_o
);
  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [AW-2:0]   remaining_q, remaining_d;
  logic [1:0]      idx_q, idx_d;
  logic [23:0]     shift_q, shift_d;
  logic [31:0]     wr_data_q, wr_data_d;
  logic            write_q, write_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0]     csum_q, csum_d;
`endif

  assign accept = bus.byte_valid_in & ready_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    wr_data_d   = wr_data_q;
    write_d     = 1'b0;
    ready_d     = ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_in) begin
          addr_d      = base_address_in & ~AW'(3);
          remaining_d = word_count_in;
          idx_d       = 2'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
          csum_d      = 32'h0;
`endif
          if (word_count_in != '0) begin
            state_d = S_COLLECT;
            ready_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            ready_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          // First byte lands in the most significant lane (big-endian).
          shift_d = {shift_q[15:0], bus.byte_data_in};
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wr_data_d = {shift_q, bus.byte_data_in};
            wr_addr_d = addr_q;
            write_d   = 1'b1;
            ready_d   = 1'b0;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        addr_d      = addr_q + AW'(4);
        remaining_d = remaining_q - (AW-1)'(1);
`ifdef MEM_LOADER_CHECKSUM_EN
        csum_d      = csum_q + wr_data_q;
`endif
        if (remaining_q == (AW-1)'(1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_COLLECT;
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      idx_q       <= 2'd0;
      shift_q     <= 24'h0;
      wr_data_q   <= 32'h0;
      write_q     <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q      <= 32'h0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      wr_data_q   <= wr_data_d;
      write_q     <= write_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.byte_ready_out    = ready_q;
  assign bus.write_data_out    = wr_data_q;
  assign bus.write_address_out = wr_addr_q;
  assign bus.write_out         = write_q;
  assign bus.memMode_out       = 2'b00;
  assign busy_out              = busy_q;
  assign done_out              = done_q;
  assign dbg_state_o           = state_q;
`ifdef MEM_LOADER_CHECKSUM_EN
  assign checksum_out          = csum_q;
`else
  assign checksum_out          = 32'h0;
`endif
endmodule

// File: doc/mem_loader.md
# mem_loader

Boot-time loader sitting directly upstream of the tri-port data/instruction memory's write port. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them in word mode to consecutive word addresses from a programmed base. Signals completion so the core can be released from reset. Owns the memory write port only while loading; read ports are untouched.

## Interface
- ADDRESS_WIDTH, 8, byte-address width of the target memory (≥ 3)
- clock_in  in  1  clock; also drives memory write_clock_in (memory writes on rising edge)
- reset_in  in  1  asynchronous, active-high reset
- start_in  in  1  begin a load; sampled only in IDLE or DONE
- base_address_in  in  ADDRESS_WIDTH  first byte address; bits [1:0] ignored (forced word-aligned)
- word_count_in  in  ADDRESS_WIDTH-1  words to load; 0 = empty load
- byte_data_in  in  8  stream byte
- byte_valid_in  in  1  byte_data_in valid
- byte_ready_out  out  1  loader accepts a byte this cycle
- write_data_out  out  32  to memory write_data_in
- write_address_out  out  ADDRESS_WIDTH  to memory write_address_in
- write_out  out  1  to memory write_in
- memMode_out  out  2  to memory memMode_in; constant 2'b00 (word)
- busy_out  out  1  high in COLLECT/WRITE
- done_out  out  1  high in DONE
- checksum_out  out  32  additive checksum (see Configuration)

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE: on start_in, latch address = {base_address_in[AW-1:2],2'b00}, remaining = word_count_in, byte index = 0, checksum = 0; go COLLECT if word_count_in ≠ 0, else DONE. DONE holds until next start_in.
- COLLECT: byte_ready_out = 1. Byte accepted when byte_valid_in & byte_ready_out at a rising edge. Byte 0 → word[31:24], byte 1 → [23:16], byte 2 → [15:8], byte 3 → [7:0]. After fourth accept → WRITE.
- WRITE (exactly one cycle): byte_ready_out = 0, write_out = 1, write_data_out = assembled word, write_address_out = current address. At the closing edge: address += 4 modulo 2^AW; remaining -= 1; checksum += word; next state DONE if remaining becomes 0, else COLLECT.
- start_in ignored in COLLECT/WRITE. Bytes offered while byte_ready_out = 0 are not consumed (source holds them).
- write_data_out/write_address_out hold last values outside WRITE; write_out = 0 outside WRITE.

## Timing
- All outputs registered; reset values: write_out 0, write_data_out 0, write_address_out 0, memMode_out 2'b00, byte_ready_out 0, busy_out 0, done_out 0, checksum_out 0; state IDLE.
- Start at edge s → byte_ready_out high from s.
- Fourth byte accepted at edge k → write_out high k..k+1; memory captures at edge k+1; byte_ready_out high again after k+1 (or done_out high after k+1 on last word).
- Peak throughput: 5 cycles per word.
- Wrap: address 2^AW-4 → 0, no flag.
- Reset mid-load: immediate return to reset values, partial word and remaining count discarded, in-flight write_out dropped asynchronously.

## Configuration
- MEM_LOADER_CHECKSUM_EN defined: 32-bit modulo-2^32 sum of every written word, cleared on accepted start, updated at WRITE closing edge; final when done_out = 1.
- Undefined: no accumulator; checksum_out tied to 32'h0.

## Test plan
- Reset, start base 0x00 count 1, bytes 00 00 00 01 → single write_out pulse, addr 0x00, data 0x00000001, memMode_out 00; done_out next cycle; memory read 0x00 = 0x00000001.
- Base 0xfc count 2, bytes 11 22 33 44 55 66 77 88 → 0x11223344 @0xfc, 0x55667788 @0x00 (wrap); done_out after second write.
- Base 0x1e count 1, bytes aa bb cc dd → write at 0x1c, data 0xaabbccdd.
- Random byte_valid_in gaps plus bytes held during WRITE → data identical to gap-free run; no byte lost or duplicated.
- Reset after 2 of 4 bytes → no write_out, all outputs at reset values; new start with fresh bytes writes correct word.
- With MEM_LOADER_CHECKSUM_EN: words 0xffffffff, 0x00000002 → checksum_out 0x00000001; start with count 0 → done_out next cycle, no write_out, checksum_out 0.
